// File: rtl/hunter_packet_tx_if.sv
// rtl/hunter_packet_tx_if.sv - request/status bundle between command front-end and packet transmitter
interface hunter_packet_tx_if #(
  parameter int ID_WIDTH     = 4,
  parameter int CMD_WIDTH    = 7,
  parameter int REPEAT_WIDTH = 3
);
  logic                    start;
  logic [ID_WIDTH-1:0]     id;
  logic [CMD_WIDTH-1:0]    cmd;
  logic [REPEAT_WIDTH-1:0] repeats;
  logic                    busy;
  logic                    done;
  logic                    out;

  modport master (output start, id, cmd, repeats, input busy, done, out);
  modport slave  (input start, id, cmd, repeats, output busy, done, out);
endinterface

// File: rtl/hunter_packet_tx.sv
// rtl/hunter_packet_tx.sv - 3-slot PWM packet serialiser with repeats and gap; HUNTER_PKT_PARITY_EN appends even parity
module hunter_packet_tx #(
  parameter int ID_WIDTH      = 4,
  parameter int CMD_WIDTH     = 7,
  parameter int LEAD_BITS     = 2,
  parameter int CLKS_PER_SLOT = 1,
  parameter int GAP_SLOTS     = 9,
  parameter int REPEAT_WIDTH  = 3
) (
  input logic              clk,
  input logic              reset,
  hunter_packet_tx_if.slave bus
);

`ifdef HUNTER_PKT_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS    = LEAD_BITS + ID_WIDTH + CMD_WIDTH + P;
  localparam int BW       = $clog2(LEAD_BITS + ID_WIDTH + CMD_WIDTH + 2);
  localparam int PW       = (CLKS_PER_SLOT > 1) ? $clog2(CLKS_PER_SLOT) : 1;
  localparam int GW       = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;
  localparam int GAP_LAST = (GAP_SLOTS > 0) ? GAP_SLOTS - 1 : 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] STOP = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]              state, n_state;
  logic [BW-1:0]           bit_idx, n_bit;
  logic [1:0]              slot, n_slot;
  logic [PW-1:0]           presc, n_presc;
  logic [GW-1:0]           gap_cnt, n_gap;
  logic [REPEAT_WIDTH-1:0] rep_cnt, n_rep;
  logic [NBITS-1:0]        frame, n_frame, shifted;
  logic                    busy_q, done_q, out_q;
  logic                    n_done, n_out, slot_adv, pkt_end;

  // Everything is computed for the position of the next cycle so out can be a plain register.
  always_comb begin
    n_state  = state;
    n_bit    = bit_idx;
    n_slot   = slot;
    n_presc  = presc;
    n_gap    = gap_cnt;
    n_rep    = rep_cnt;
    n_frame  = frame;
    n_done   = 1'b0;
    pkt_end  = 1'b0;
    slot_adv = (presc == PW'(CLKS_PER_SLOT - 1));

    if (state != IDLE) begin
      n_presc = slot_adv ? '0 : presc + PW'(1);
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
          n_state = SEND;
          n_bit   = '0;
          n_slot  = 2'd0;
          n_presc = '0;
          n_gap   = '0;
          n_rep   = bus.repeats;
          n_frame = NBITS'({bus.cmd, bus.id}) << LEAD_BITS;
`ifdef HUNTER_PKT_PARITY_EN
          n_frame[NBITS-1] = ^{bus.cmd, bus.id};
`endif
        end
      end
      SEND: begin
        if (slot_adv) begin
          if (slot == 2'd2) begin
            n_slot = 2'd0;
            if (bit_idx == BW'(NBITS - 1)) begin
              n_state = STOP;
              n_bit   = '0;
            end else begin
              n_bit = bit_idx + BW'(1);
            end
          end else begin
            n_slot = slot + 2'd1;
          end
        end
      end
      STOP: begin
        if (slot_adv) begin
          if (slot == 2'd2) begin
            n_slot = 2'd0;
            if (GAP_SLOTS == 0) begin
              pkt_end = 1'b1;
            end else begin
              n_state = GAP;
              n_gap   = '0;
            end
          end else begin
            n_slot = slot + 2'd1;
          end
        end
      end
      GAP: begin
        if (slot_adv) begin
          if (gap_cnt == GW'(GAP_LAST)) begin
            pkt_end = 1'b1;
          end else begin
            n_gap = gap_cnt + GW'(1);
          end
        end
      end
      default: n_state = IDLE;
    endcase

    if (pkt_end) begin
      n_gap  = '0;
      n_bit  = '0;
      n_slot = 2'd0;
      if (rep_cnt != '0) begin
        n_rep   = rep_cnt - REPEAT_WIDTH'(1);
        n_state = SEND;
      end else begin
        n_state = IDLE;
        n_done  = 1'b1;
      end
    end

    shifted = n_frame >> n_bit;
    n_out   = (n_state == SEND) && ((n_slot == 2'd2) || ((n_slot == 2'd1) && shifted[0]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      slot    <= 2'd0;
      presc   <= '0;
      gap_cnt <= '0;
      rep_cnt <= '0;
      frame   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state   <= n_state;
      bit_idx <= n_bit;
      slot    <= n_slot;
      presc   <= n_presc;
      gap_cnt <= n_gap;
      rep_cnt <= n_rep;
      frame   <= n_frame;
      busy_q  <= (n_state != IDLE);
      done_q  <= n_done;
      out_q   <= n_out;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

// File: doc/hunter_packet_tx.md
Name: hunter_packet_tx

Overview:
- Parametrised successor of the fixed-pattern fan-remote packet generator.
- Serialises a run-time ID and command into the 3-slot PWM bit encoding: low, data, high.
- Adds a start/busy/done handshake, a slot-rate prescaler, a programmable repeat count and an inter-packet gap.
- Sits between the command front-end and the RF/IR transmitter driver pin.

Parameters:
- ID_WIDTH, 4, width of the device ID field.
- CMD_WIDTH, 7, width of the command field.
- LEAD_BITS, 2, number of leading zero-data bits sent before the ID. Must be >= 0.
- CLKS_PER_SLOT, 1, clk cycles per PWM slot. Must be >= 1.
- GAP_SLOTS, 9, low slots inserted after each packet's stop bit. Must be >= 0.
- REPEAT_WIDTH, 3, width of the repeats input.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request to send; sampled only while busy=0.
- id, input, ID_WIDTH, device ID; latched on start acceptance.
- cmd, input, CMD_WIDTH, command; latched on start acceptance.
- repeats, input, REPEAT_WIDTH, extra transmissions; total packets = repeats+1; latched on acceptance.
- busy, output, 1, high from the cycle after acceptance until frame end.
- done, output, 1, one-cycle pulse at frame end.
- out, output, 1, registered PWM line.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: out=0, busy=0, done=0, state IDLE, all counters 0. Reset has priority over every other event.
- Reset mid-frame aborts immediately: out=0 on the next cycle; no done pulse.
- States: IDLE, SEND, STOP, GAP.
- IDLE -> SEND when start=1 at a clk edge with busy=0.
  - Latch id, cmd and repeats. busy=1 from that edge. Slot 0 of bit 0 begins at the same edge.
  - start while busy=1 is ignored and not queued.
- Bit encoding: each bit is 3 slots, each CLKS_PER_SLOT cycles long.
  - slot0: out=0.
  - slot1: out=data.
  - slot2: out=1.
- Bit order in SEND:
  - LEAD_BITS zeros.
  - id LSB first.
  - cmd LSB first.
  - [parity, see Optional Feature].
- SEND -> STOP after slot2 of the last data bit.
- STOP: one bit time (3 slots) with out=0 in every slot.
- STOP -> GAP. GAP lasts GAP_SLOTS slots with out=0. If GAP_SLOTS=0, GAP is skipped.
- End of GAP:
  - If the repeat counter is nonzero: decrement it, restart SEND at bit 0 with the same latched data.
  - Otherwise: -> IDLE, busy=0 and done=1 in the same cycle. done is high for exactly 1 cycle.
  - A new start is accepted at the earliest in the cycle after done.
- Frame length in cycles:
  - F = (repeats+1) * CLKS_PER_SLOT * (3*(LEAD_BITS+ID_WIDTH+CMD_WIDTH+P+1) + GAP_SLOTS).
  - P = 1 with parity enabled, else 0.
  - busy is high for exactly F cycles.
- Prescaler: counts 0..CLKS_PER_SLOT-1 and wraps; the slot advances on wrap. With CLKS_PER_SLOT=1 the slot advances every cycle.
- Bit counter width: $clog2(LEAD_BITS+ID_WIDTH+CMD_WIDTH+2). Repeat counter width: REPEAT_WIDTH.
- repeats at maximum (all ones): 2^REPEAT_WIDTH packets sent, no wrap.
- Inputs id, cmd and repeats may change while busy with no effect on the frame in progress.
- out in IDLE is 0.

Optional Feature:
- Macro: HUNTER_PKT_PARITY_EN.
- Defined: one parity bit is appended after cmd MSB. Value = XOR of all latched id and cmd bits (even parity). It uses the normal 3-slot encoding; P=1.
- Undefined: no parity bit, P=0, and no parity logic is synthesised.

Test Plan:
- Defaults, id=4'b1010, cmd=7'b0010111, repeats=0, pulse start -> the 13 data bits are 0,0,0,1,0,1,1,1,1,0,1,0,0.
  - out follows 0,d,1 per bit, then 3 low (STOP) and 9 low (GAP).
  - busy high for 51 cycles; done is 1 cycle, aligned with busy falling.
- CLKS_PER_SLOT=4, same data -> every slot is stretched to 4 cycles; busy = 204 cycles.
- repeats=2 -> three identical packets, each separated by a 3-slot STOP plus a 9-slot GAP; busy = 153 cycles; a single done pulse.
- start pulses at cycles 5 and 20 of a frame, and id changed mid-frame -> ignored; output is bit-identical to the undisturbed frame.
- reset asserted at cycle 17 of a frame -> out=0, busy=0, done=0 next cycle. A start 2 cycles later produces a complete, correct frame.
- With HUNTER_PKT_PARITY_EN, id=4'b0001, cmd=7'b0000000 -> parity bit = 1, sent after cmd. busy = 54 cycles (defaults). Same stimulus without the macro -> 51 cycles.
